dma_tcdm_burst_reader: RTL and testbench

// - Read-only, parametrised AXI-style burst to multi-bank TCDM adapter for the cluster DMA TCDM read path.
// - Takes INCR bursts on an AR/R valid-ready pair and splits every beat across NumBanks TCDM master ports.
// - Each bank runs its own handshake and its own response buffer, so one stalled bank does not block the others.
// - Generalises the fixed 2-bank, depth-1 split: bank count, buffer depth and ID width are parameters.

---
 rtl/dma_tcdm_burst_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_dma_tcdm_burst_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_tcdm_burst_reader.sv
// AXI-style INCR read bursts split across NumBanks TCDM ports, each bank with its own response buffer.
// Latency: a granted word reaches R two cycles after its grant at the earliest; the buffers have no fall-through.
// Backpressure: R stalls hold the bank buffers; each bank stops requesting once its credits run out, independently of the others.

// Small generic FIFO: registered storage, no fall-through, and a push into a full FIFO is accepted when a pop happens in the same cycle.
module dma_tcdm_burst_reader_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_q, wr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CntW'(Depth)) || do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end
endmodule

module dma_tcdm_burst_reader #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumBanks  = 2,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned BufDepth  = 2,
    parameter int unsigned CmdDepth  = 2,
    localparam int unsigned BankWidth = DataWidth / NumBanks
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           ar_valid_i,
    output logic                           ar_ready_o,
    input  logic [AddrWidth-1:0]           ar_addr_i,
    input  logic [7:0]                     ar_len_i,
    input  logic [IdWidth-1:0]             ar_id_i,
    output logic                           r_valid_o,
    input  logic                           r_ready_i,
    output logic [DataWidth-1:0]           r_data_o,
    output logic [IdWidth-1:0]             r_id_o,
    output logic                           r_last_o,
    output logic [NumBanks-1:0]            mem_req_o,
    input  logic [NumBanks-1:0]            mem_gnt_i,
    output logic [NumBanks*AddrWidth-1:0]  mem_addr_o,
    input  logic [NumBanks-1:0]            mem_rvalid_i,
    input  logic [NumBanks*BankWidth-1:0]  mem_rdata_i,
    output logic                           busy_o
);
    localparam int unsigned BeatBytes = DataWidth / 8;
    localparam int unsigned BankBytes = BankWidth / 8;
    localparam int unsigned BufCntW   = $clog2(BufDepth + 1);
    localparam int unsigned CreditW   = BufCntW + 1;
    localparam int unsigned CmdCntW   = $clog2(CmdDepth + 1);

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [7:0]         len;
    } cmd_t;

    state_e               state_q;
    logic                 ar_ready_q;
    logic [AddrWidth-1:0] beat_addr_q;
    logic [8:0]           beats_q;
    logic [8:0]           ptr_q [NumBanks];
    logic [8:0]           ptr_d [NumBanks];
    logic [BufCntW-1:0]   outst_q [NumBanks];
    logic [7:0]           beat_cnt_q;

    logic [NumBanks-1:0]  req_d, grant, credit_ok;
    logic                 issue_done;
    logic                 ar_fire, r_fire, r_last_int, cmd_pop;

    logic [NumBanks-1:0]  buf_push, buf_nonempty;
    logic [BufCntW-1:0]   buf_cnt [NumBanks];
    logic [BankWidth-1:0] buf_dat [NumBanks];

    cmd_t                 cmd_in, cmd_head;
    logic [CmdCntW-1:0]   cmd_cnt, cmd_cnt_nxt;
    logic                 cmd_nonempty;

    assign ar_ready_o   = ar_ready_q;
    assign ar_fire      = ar_valid_i && ar_ready_q;
    assign cmd_in       = '{id: ar_id_i, len: ar_len_i};
    assign cmd_nonempty = (cmd_cnt != '0);
    assign r_valid_o    = (&buf_nonempty) && cmd_nonempty;
    assign r_fire       = r_valid_o && r_ready_i;
    assign r_last_int   = (beat_cnt_q == cmd_head.len);
    assign cmd_pop      = r_fire && r_last_int;
    assign cmd_cnt_nxt  = cmd_cnt + CmdCntW'(ar_fire) - CmdCntW'(cmd_pop);
    assign r_id_o       = r_valid_o ? cmd_head.id : '0;
    assign r_last_o     = r_valid_o && r_last_int;
    assign busy_o       = (state_q != IDLE) || cmd_nonempty;
    assign mem_req_o    = req_d;

    // Per-bank request, credit and address generation; addresses read as zero while no request is up.
    always_comb begin
        issue_done = 1'b1;
        mem_addr_o = '0;
        for (int b = 0; b < int'(NumBanks); b++) begin
            credit_ok[b] = (CreditW'(outst_q[b]) + CreditW'(buf_cnt[b])) < CreditW'(BufDepth);
            req_d[b]     = (state_q == ISSUE) && (ptr_q[b] != beats_q) && credit_ok[b];
            grant[b]     = req_d[b] && mem_gnt_i[b];
            ptr_d[b]     = ptr_q[b] + 9'(grant[b]);
            issue_done   = issue_done && (ptr_d[b] == beats_q);
            buf_push[b]  = mem_rvalid_i[b] && (outst_q[b] != '0);
            buf_nonempty[b] = (buf_cnt[b] != '0);
            if (req_d[b]) begin
                mem_addr_o[b*AddrWidth +: AddrWidth] = beat_addr_q
                    + AddrWidth'(ptr_q[b]) * AddrWidth'(BeatBytes)
                    + AddrWidth'(b * int'(BankBytes));
            end
        end
    end

    // Beat data is only driven while a beat is being offered.
    always_comb begin
        r_data_o = '0;
        for (int b = 0; b < int'(NumBanks); b++) begin
            if (r_valid_o) r_data_o[b*BankWidth +: BankWidth] = buf_dat[b];
        end
    end

    // Issue FSM: accepts one burst, walks each bank pointer through it, and registers AR readiness for the next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ar_ready_q  <= 1'b0;
            beat_addr_q <= '0;
            beats_q     <= '0;
            for (int b = 0; b < int'(NumBanks); b++) ptr_q[b] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_fire) begin
                        state_q     <= ISSUE;
                        ar_ready_q  <= 1'b0;
                        beat_addr_q <= ar_addr_i & ~AddrWidth'(BeatBytes - 1);
                        beats_q     <= {1'b0, ar_len_i} + 9'd1;
                        for (int b = 0; b < int'(NumBanks); b++) ptr_q[b] <= '0;
                    end else begin
                        ar_ready_q <= (cmd_cnt_nxt != CmdCntW'(CmdDepth));
                    end
                end
                ISSUE: begin
                    for (int b = 0; b < int'(NumBanks); b++) ptr_q[b] <= ptr_d[b];
                    if (issue_done) begin
                        state_q    <= IDLE;
                        ar_ready_q <= (cmd_cnt_nxt != CmdCntW'(CmdDepth));
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ar_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Granted-but-not-returned words per bank; TCDM answers exactly one cycle after a grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < int'(NumBanks); b++) outst_q[b] <= '0;
        end else begin
            for (int b = 0; b < int'(NumBanks); b++)
                outst_q[b] <= outst_q[b] + BufCntW'(grant[b]) - BufCntW'(buf_push[b]);
        end
    end

    // Beat counter within the burst at the head of the command FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
        end else if (r_fire) begin
            beat_cnt_q <= r_last_int ? 8'd0 : beat_cnt_q + 8'd1;
        end
    end

    dma_tcdm_burst_reader_fifo #(
        .Width ($bits(cmd_t)),
        .Depth (CmdDepth)
    ) i_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ar_fire),
        .data_i  (cmd_in),
        .pop_i   (cmd_pop),
        .data_o  (cmd_head),
        .count_o (cmd_cnt)
    );

    for (genvar g = 0; g < int'(NumBanks); g++) begin : gen_bank
        dma_tcdm_burst_reader_fifo #(
            .Width (BankWidth),
            .Depth (BufDepth)
        ) i_buf (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (buf_push[g]),
            .data_i  (mem_rdata_i[g*BankWidth +: BankWidth]),
            .pop_i   (r_fire),
            .data_o  (buf_dat[g]),
            .count_o (buf_cnt[g])
        );

        // The credit rule must keep read data from ever arriving at a full buffer that is not draining.
        assert property (@(posedge clk_i) disable iff (rst_i)
            !(buf_push[g] && (buf_cnt[g] == BufCntW'(BufDepth)) && !r_fire));
    end
endmodule

// File: tb/tb_dma_tcdm_burst_reader.sv
module tb_dma_tcdm_burst_reader;
    localparam int AW = 32, DW = 64, NB = 2, BW = DW / NB, IW = 4, BUF = 2;
    localparam int BEATB = DW / 8, BANKB = BW / 8;

    logic              clk_i, rst_i;
    logic              ar_valid_i, ar_ready_o;
    logic [AW-1:0]     ar_addr_i;
    logic [7:0]        ar_len_i;
    logic [IW-1:0]     ar_id_i;
    logic              r_valid_o, r_ready_i, r_last_o;
    logic [DW-1:0]     r_data_o;
    logic [IW-1:0]     r_id_o;
    logic [NB-1:0]     mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [NB*AW-1:0]  mem_addr_o;
    logic [NB*BW-1:0]  mem_rdata_i;
    logic              busy_o;

    dma_tcdm_burst_reader dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_id_o(r_id_o), .r_last_o(r_last_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    typedef struct {
        logic [NB-1:0][AW-1:0] addr;
        logic [IW-1:0]         id;
        logic                  last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } burst_t;

    beat_t  beats[$];
    int     gcyc[$];
    burst_t ar_q[$];
    int     gi[NB];
    int     ri, acc_cnt, done_cnt, cyc;
    logic   pend_vld[NB];
    logic [AW-1:0] pend_addr[NB];
    int     gnt_pct, rdy_pct, skew_cyc, hold_cyc;
    int     last_lat, ar_gap, last_gnt_cyc, peak;
    logic   ar_fired;
    int     n_chk, n_pass;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Memory contents: a fixed scramble of the bank word address.
    function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic add_burst(input logic [AW-1:0] a, input logic [7:0] len, input logic [IW-1:0] id);
        burst_t t;
        t.addr = a; t.len = len; t.id = id;
        ar_q.push_back(t);
    endtask

    task automatic monitor();
        beat_t          e;
        logic [DW-1:0]  ed;
        logic [AW-1:0]  al;
        int             g;
        check("busy", busy_o, acc_cnt != done_cnt);
        for (int b = 0; b < NB; b++) begin
            pend_vld[b] = 1'b0;
            if (mem_req_o[b] && mem_gnt_i[b]) begin
                check("gnt_spurious", gi[b] < beats.size(), 1);
                if (gi[b] < beats.size()) begin
                    check("credit", (gi[b] - ri) < BUF, 1);
                    check("mem_addr", mem_addr_o[b*AW +: AW], beats[gi[b]].addr[b]);
                    if (gi[b] + 1 - ri > peak) peak = gi[b] + 1 - ri;
                    gcyc[gi[b]*NB + b] = cyc;
                    gi[b]++;
                    pend_vld[b]  = 1'b1;
                    pend_addr[b] = mem_addr_o[b*AW +: AW];
                    last_gnt_cyc = cyc;
                end
            end
        end
        if (r_valid_o && r_ready_i) begin
            check("r_spurious", ri < beats.size(), 1);
            if (ri < beats.size()) begin
                e = beats[ri];
                g = 0;
                for (int b = 0; b < NB; b++) begin
                    ed[b*BW +: BW] = mem_word(e.addr[b]);
                    if (gcyc[ri*NB + b] > g) g = gcyc[ri*NB + b];
                end
                check("r_data", r_data_o, ed);
                check("r_id", r_id_o, e.id);
                check("r_last", r_last_o, e.last);
                last_lat = cyc - g;
                check("r_latency", last_lat >= 2, 1);
                ri++;
                if (e.last) done_cnt++;
            end
        end
        if (ar_valid_i && ar_ready_o && !ar_fired) begin
            ar_gap = cyc - last_gnt_cyc;
            al = ar_addr_i & ~AW'(BEATB - 1);
            for (int k = 0; k <= int'(ar_len_i); k++) begin
                for (int b = 0; b < NB; b++) begin
                    e.addr[b] = al + AW'(k * BEATB + b * BANKB);
                    gcyc.push_back(1 << 30);
                end
                e.id   = ar_id_i;
                e.last = (k == int'(ar_len_i));
                beats.push_back(e);
            end
            acc_cnt++;
            ar_fired = 1'b1;
        end
    endtask

    task automatic step();
        burst_t t;
        @(posedge clk_i);
        #1;
        cyc++;
        for (int b = 0; b < NB; b++) begin
            mem_rvalid_i[b] = pend_vld[b];
            mem_rdata_i[b*BW +: BW] = pend_vld[b] ? mem_word(pend_addr[b]) : BW'($urandom);
        end
        if (ar_fired) begin
            ar_valid_i = 1'b0;
            ar_fired   = 1'b0;
        end
        if (!ar_valid_i && ar_q.size() > 0) begin
            t = ar_q.pop_front();
            ar_addr_i  = t.addr;
            ar_len_i   = t.len;
            ar_id_i    = t.id;
            ar_valid_i = 1'b1;
        end
        @(negedge clk_i);
        for (int b = 0; b < NB; b++) mem_gnt_i[b] = ($urandom_range(99) < gnt_pct);
        if (skew_cyc > 0 && mem_req_o[1]) begin
            mem_gnt_i[1] = 1'b0;
            skew_cyc--;
        end
        r_ready_i = ($urandom_range(99) < rdy_pct);
        if (hold_cyc > 0) begin
            r_ready_i = 1'b0;
            if (busy_o) hold_cyc--;
        end
        #1;
        monitor();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((ar_q.size() > 0 || (ar_valid_i && !ar_fired) || ri < beats.size()) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", (ri < beats.size()) || ar_q.size() > 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        n_chk = 0; n_pass = 0; cyc = 0; ri = 0; acc_cnt = 0; done_cnt = 0;
        last_lat = 0; ar_gap = 0; last_gnt_cyc = 0; peak = 0; ar_fired = 1'b0;
        gnt_pct = 100; rdy_pct = 100; skew_cyc = 0; hold_cyc = 0;
        for (int b = 0; b < NB; b++) begin gi[b] = 0; pend_vld[b] = 1'b0; pend_addr[b] = '0; end
        rst_i = 1'b1; ar_valid_i = 1'b0; ar_addr_i = '0; ar_len_i = '0; ar_id_i = '0;
        r_ready_i = 1'b0; mem_gnt_i = '0; mem_rvalid_i = '0; mem_rdata_i = '0;
        #12;
        check("rst_ar_ready", ar_ready_o, 0);
        check("rst_r_valid", r_valid_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_r_data", r_data_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single beat at 0x100: words at 0x100/0x104, ID 3, last, two cycles after grant.
        add_burst(32'h100, 8'd0, 4'd3);
        drain(200);
        check("single_latency", last_lat, 2);

        // Bank 1 grant withheld: bank 0 must stop at the buffer depth.
        peak = 0; skew_cyc = 4;
        add_burst($urandom, 8'd3, 4'd5);
        drain(200);
        check("skew_peak_credit", peak, BUF);

        // R held off: requests stop once credits are exhausted.
        peak = 0; hold_cyc = 10;
        add_burst($urandom, 8'd7, 4'd6);
        drain(300);
        check("bp_peak_credit", peak, BUF);

        // Back-to-back: second AR taken the cycle after issue of the first ends.
        add_burst(32'h400, 8'd1, 4'd1);
        add_burst(32'h800, 8'd0, 4'd2);
        drain(200);
        check("b2b_ar_gap", ar_gap, 1);

        // Address wrap past the top of the space.
        add_burst(32'hFFFF_FFF8, 8'd1, 4'd7);
        drain(200);

        // Reset in the middle of a burst.
        base = beats.size();
        add_burst(32'h2000, 8'd3, 4'd9);
        for (int n = 0; n < 100 && ri < base + 1; n++) step();
        check("rst_burst_started", ri >= base + 1, 1);
        step();
        rst_i = 1'b1;
        #1;
        check("midrst_r_valid", r_valid_o, 0);
        check("midrst_mem_req", mem_req_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_ar_ready", ar_ready_o, 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        #1;
        rst_i = 1'b0;
        for (int b = 0; b < NB; b++) gi[b] = beats.size();
        ri = beats.size(); acc_cnt = 0; done_cnt = 0;
        ar_fired = 1'b0; ar_valid_i = 1'b0;
        add_burst(32'h3008, 8'd2, 4'd10);
        drain(200);

        // Randomised traffic under moderate and heavy stalls.
        gnt_pct = 70; rdy_pct = 75;
        for (int i = 0; i < 40; i++)
            add_burst($urandom, 8'($urandom_range(15)), IW'($urandom));
        drain(8000);
        gnt_pct = 30; rdy_pct = 40;
        for (int i = 0; i < 20; i++)
            add_burst($urandom, 8'($urandom_range(9)), IW'($urandom));
        drain(8000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
